// File: rtl/ped_crossing_if.sv
// Signal bundle between the vehicle light FSM, the push-button and the
// pedestrian crossing controller.
interface ped_crossing_if #(
  parameter int CNT_W = 4
);
  logic             car_red_i;
  logic             car_yellow_i;
  logic             car_green_i;
  logic             btn_i;
  logic             walk_o;
  logic             stop_o;
  logic             req_pending_o;
  logic [CNT_W-1:0] countdown_o;
  logic             fault_o;

  modport master (
    output car_red_i, car_yellow_i, car_green_i, btn_i,
    input  walk_o, stop_o, req_pending_o, countdown_o, fault_o
  );

  modport slave (
    input  car_red_i, car_yellow_i, car_green_i, btn_i,
    output walk_o, stop_o, req_pending_o, countdown_o, fault_o
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian WALK / flashing DON'T-WALK controller gated by a clean car-red window.
// Define PED_AUTO_REQ_EN to grant a crossing in every red window without a button.
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 6,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  ped_crossing_if.slave bus
);

  if (WALK_CYCLES + FLASH_CYCLES - 1 >= (1 << CNT_W)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for WALK_CYCLES+FLASH_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] LOAD =
    CNT_W'(WALK_CYCLES + FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD =
    CNT_W'(FLASH_CYCLES);
  localparam logic [CNT_W-1:0] FLASH_TOP =
    CNT_W'(FLASH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WALK,
    S_FLASH,
    S_CLEAR
  } state_t;

  state_t           st, nxt;
  logic             red_q;
  logic             b1, b2, b3;
  logic             req, req_nxt, req_eff;
  logic             fault, fault_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             grant;
  logic             walk, stop;

  wire red_only = bus.car_red_i & ~bus.car_yellow_i & ~bus.car_green_i;
  wire red_rise = red_only & ~red_q;
  wire btn_edge = b2 & ~b3;

`ifdef PED_AUTO_REQ_EN
  assign req_eff = 1'b1;
`else
  assign req_eff = req;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st    <= S_IDLE;
      red_q <= 1'b0;
      b1    <= 1'b0;
      b2    <= 1'b0;
      b3    <= 1'b0;
      req   <= 1'b0;
      fault <= 1'b0;
      cnt   <= '0;
    end else begin
      st    <= nxt;
      red_q <= red_only;
      b1    <= bus.btn_i;
      b2    <= b1;
      b3    <= b2;
      req   <= req_nxt;
      fault <= fault_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt       = st;
    cnt_nxt   = '0;
    fault_nxt = fault;
    grant     = 1'b0;
    walk      = 1'b0;
    stop      = 1'b1;
    unique case (st)
      S_IDLE: begin
        if (req_eff) nxt = S_WAIT;
      end
      S_WAIT: begin
        if (red_rise && !fault) begin
          nxt     = S_WALK;
          grant   = 1'b1;
          cnt_nxt = LOAD;
        end
      end
      S_WALK: begin
        walk = 1'b1;
        stop = 1'b0;
        if (!red_only) begin
          fault_nxt = 1'b1;
          nxt       = S_CLEAR;
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == FLASH_LOAD) nxt = S_FLASH;
        end
      end
      S_FLASH: begin
        // first flash clock shows stop, then it alternates
        stop = ~(cnt[0] ^ FLASH_TOP[0]);
        if (!red_only) begin
          fault_nxt = 1'b1;
          nxt       = S_CLEAR;
        end else if (cnt == '0) begin
          nxt = S_CLEAR;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_CLEAR: begin
        if (!red_only) nxt = req_eff ? S_WAIT : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    // a grant swallows any edge arriving with it
    req_nxt = grant ? 1'b0 : (req | btn_edge);
  end

  assign bus.walk_o        = walk;
  assign bus.stop_o        = stop;
  assign bus.req_pending_o = req;
  assign bus.countdown_o   = cnt;
  assign bus.fault_o       = fault;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: a cycle table for one full crossing,
// then hand sequences for red-at-request, re-press, safety fault and async reset.
module tb_ped_crossing_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ped_crossing_if #(.CNT_W(4)) bus ();

  ped_crossing_ctrl #(
    .WALK_CYCLES (6),
    .FLASH_CYCLES(4),
    .CNT_W       (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic       r, y, g, b;
    logic       w, s, p;
    logic [3:0] c;
    logic       f;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic outs(input string tag, input logic w, input logic s,
                      input logic p, input logic [3:0] c, input logic f);
    chk({tag, " walk"}, bus.walk_o, w);
    chk({tag, " stop"}, bus.stop_o, s);
    chk({tag, " req"}, bus.req_pending_o, p);
    chk({tag, " cnt"}, bus.countdown_o, c);
    chk({tag, " fault"}, bus.fault_o, f);
  endtask

  task automatic car(input logic r, input logic y, input logic g);
    bus.car_red_i    = r;
    bus.car_yellow_i = y;
    bus.car_green_i  = g;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // r y g b | walk stop req cnt fault (after the clock edge)
    tbl[0]  = '{0, 0, 1, 1, 0, 1, 0, 4'd0, 0};
    tbl[1]  = '{0, 0, 1, 1, 0, 1, 0, 4'd0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 1, 1, 4'd0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 1, 1, 4'd0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 1, 4'd0, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 0, 0, 4'd9, 0};
    tbl[6]  = '{1, 0, 0, 0, 1, 0, 0, 4'd8, 0};
    tbl[7]  = '{1, 0, 0, 0, 1, 0, 0, 4'd7, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 0, 0, 4'd6, 0};
    tbl[9]  = '{1, 0, 0, 0, 1, 0, 0, 4'd5, 0};
    tbl[10] = '{1, 0, 0, 0, 1, 0, 0, 4'd4, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0, 4'd3, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 4'd2, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 1, 0, 4'd1, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 4'd0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 1, 0, 4'd0, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 1, 0, 4'd0, 0};
    tbl[17] = '{0, 0, 1, 0, 0, 1, 0, 4'd0, 0};

    rst = 1'b1;
    bus.btn_i = 1'b0;
    car(0, 0, 1);
    #3;
    outs("reset", 0, 1, 0, 4'd0, 0);
    tick(2);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      car(tbl[i].r, tbl[i].y, tbl[i].g);
      bus.btn_i = tbl[i].b;
      tick(1);
      outs($sformatf("vec%0d", i), tbl[i].w, tbl[i].s, tbl[i].p,
           tbl[i].c, tbl[i].f);
    end

    // three car cycles with no button
    for (int k = 0; k < 33; k++) begin
      if (k % 11 < 4) car(0, 0, 1);
      else if (k % 11 < 6) car(0, 1, 0);
      else car(1, 0, 0);
      tick(1);
      chk("idle walk", bus.walk_o, 1'b0);
      chk("idle stop", bus.stop_o, 1'b1);
    end

    // press while red already active: no grant in this window
    bus.btn_i = 1'b1;
    tick(1);
    bus.btn_i = 1'b0;
    tick(1);
    chk("red req 2clk", bus.req_pending_o, 1'b0);
    tick(1);
    chk("red req 3clk", bus.req_pending_o, 1'b1);
    tick(1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("red no grant", bus.walk_o, 1'b0);
    end
    car(0, 0, 1);
    tick(2);
    car(0, 1, 0);
    tick(1);
    car(1, 0, 0);
    tick(1);
    outs("next red", 1, 0, 0, 4'd9, 0);

    // second press during WALK
    bus.btn_i = 1'b1;
    tick(1);
    bus.btn_i = 1'b0;
    tick(1);
    chk("walk req 2clk", bus.req_pending_o, 1'b0);
    tick(1);
    chk("walk req 3clk", bus.req_pending_o, 1'b1);
    tick(9);
    outs("clear held", 0, 1, 1, 4'd0, 0);
    tick(2);
    chk("no regrant", bus.walk_o, 1'b0);
    car(0, 0, 1);
    tick(1);
    car(0, 1, 0);
    tick(1);
    car(1, 0, 0);
    tick(1);
    outs("regrant", 1, 0, 0, 4'd9, 0);

    // yellow at WALK clock 3
    tick(2);
    chk("pre fault cnt", bus.countdown_o, 4'd7);
    car(0, 1, 0);
    tick(1);
    outs("fault", 0, 1, 0, 4'd0, 1);
    tick(1);
    car(0, 0, 1);
    bus.btn_i = 1'b1;
    tick(1);
    bus.btn_i = 1'b0;
    tick(2);
    chk("fault req", bus.req_pending_o, 1'b1);
    tick(1);
    car(0, 1, 0);
    tick(1);
    car(1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("fault no grant", bus.walk_o, 1'b0);
    end
    car(0, 0, 1);
    tick(2);
    car(0, 1, 0);
    tick(1);
    car(1, 0, 0);
    tick(3);
    outs("fault hold", 0, 1, 1, 4'd0, 1);

    // reset clears fault immediately
    rst = 1'b1;
    #1;
    outs("rst fault", 0, 1, 0, 4'd0, 0);
    tick(1);
    rst = 1'b0;

    // async reset in the middle of FLASH
    car(0, 0, 1);
    bus.btn_i = 1'b1;
    tick(1);
    bus.btn_i = 1'b0;
    tick(3);
    car(0, 1, 0);
    tick(1);
    car(1, 0, 0);
    tick(1);
    chk("g3 walk", bus.walk_o, 1'b1);
    tick(7);
    chk("flash cnt", bus.countdown_o, 4'd2);
    chk("flash stop", bus.stop_o, 1'b0);
    rst = 1'b1;
    #1;
    outs("async rst", 0, 1, 0, 4'd0, 0);
    tick(1);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
